// File: rtl/nrzi_unstuff_receiver.sv
// Line-side receive front end: SYNC detection, NRZI decode, bit unstuffing,
// EOP detection and line-error reporting. One clk is one bit time.
module nrzi_unstuff_receiver #(
  parameter int STUFF_LEN = 6,
  parameter int EOP_SE0   = 2,
  parameter int IDLE_J    = 8,
  parameter int MAX_BITS  = 96
) (
  input  logic clk,
  input  logic rst,
  input  logic dp,
  input  logic dm,
  output logic inb,
  output logic recving,
  output logic pause,
  output logic rx_error
);

  localparam int BW = $clog2(MAX_BITS + 2);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int IW = $clog2(IDLE_J + 1);
  localparam int EW = $clog2(EOP_SE0 + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SYNC      = 3'd1,
    S_RECV      = 3'd2,
    S_EOP       = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          prev_q, prev_d;
  logic [2:0]    sync_cnt_q, sync_cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [EW-1:0] eop_q, eop_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          inb_q, inb_d;
  logic          recving_q, recving_d;
  logic          pause_q, pause_d;
  logic          err_q, err_d;

  logic [1:0] line_s;
  logic       is_j_s, is_k_s, is_se0_s, is_jk_s, lvl_s, dbit_s;

  assign line_s   = {dp, dm};
  assign is_j_s   = (line_s == 2'b10);
  assign is_k_s   = (line_s == 2'b01);
  assign is_se0_s = (line_s == 2'b00);
  assign is_jk_s  = is_j_s | is_k_s;
  // prev_q holds the last J/K level: 1 = J, 0 = K
  assign lvl_s    = is_j_s;
  assign dbit_s   = (lvl_s == prev_q);

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    eop_d      = eop_q;
    idle_d     = idle_q;
    inb_d      = 1'b0;
    recving_d  = 1'b0;
    pause_d    = 1'b0;
    err_d      = 1'b0;

    if (is_jk_s) begin
      prev_d = lvl_s;
    end else begin
      prev_d = prev_q;
    end

    case (state_q)
      S_IDLE: begin
        if (is_j_s) begin
          state_d = S_IDLE;
        end else if (is_k_s) begin
          // this K is already decoded SYNC bit 0
          state_d    = S_SYNC;
          sync_cnt_d = 3'd1;
        end else begin
          state_d = S_WAIT_IDLE;
          idle_d  = '0;
        end
      end

      S_SYNC: begin
        if (is_jk_s) begin
          if (sync_cnt_q == 3'd7) begin
            if (dbit_s) begin
              state_d = S_RECV;
              ones_d  = OW'(1);
              bit_d   = '0;
            end else begin
              state_d = S_WAIT_IDLE;
              idle_d  = '0;
            end
          end else if (dbit_s) begin
            state_d = S_WAIT_IDLE;
            idle_d  = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end else begin
          state_d = S_WAIT_IDLE;
          idle_d  = '0;
        end
      end

      S_RECV: begin
        if (is_se0_s) begin
          state_d = S_EOP;
          eop_d   = EW'(1);
        end else if (!is_jk_s) begin
          err_d   = 1'b1;
          state_d = S_WAIT_IDLE;
          idle_d  = '0;
        end else if (ones_q == OW'(STUFF_LEN)) begin
          if (dbit_s) begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
            idle_d  = '0;
          end else begin
            pause_d   = 1'b1;
            recving_d = 1'b1;
            ones_d    = '0;
          end
        end else if (bit_q == BW'(MAX_BITS)) begin
          // this bit would be number MAX_BITS+1
          err_d   = 1'b1;
          bit_d   = BW'(MAX_BITS + 1);
          state_d = S_WAIT_IDLE;
          idle_d  = '0;
        end else begin
          inb_d     = dbit_s;
          recving_d = 1'b1;
          bit_d     = bit_q + BW'(1);
          if (dbit_s) begin
            ones_d = ones_q + OW'(1);
          end else begin
            ones_d = '0;
          end
        end
      end

      S_EOP: begin
        if (is_se0_s) begin
          if (eop_q == EW'(EOP_SE0)) begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
            idle_d  = '0;
          end else begin
            eop_d = eop_q + EW'(1);
          end
        end else if (is_j_s && (eop_q == EW'(EOP_SE0))) begin
          state_d = S_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = S_WAIT_IDLE;
          idle_d  = '0;
        end
      end

      S_WAIT_IDLE: begin
        if (is_j_s) begin
          if (idle_q == IW'(IDLE_J - 1)) begin
            state_d = S_IDLE;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end else begin
          idle_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prev_q     <= 1'b1;
      sync_cnt_q <= 3'd0;
      ones_q     <= '0;
      bit_q      <= '0;
      eop_q      <= '0;
      idle_q     <= '0;
      inb_q      <= 1'b0;
      recving_q  <= 1'b0;
      pause_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sync_cnt_q <= sync_cnt_d;
      ones_q     <= ones_d;
      bit_q      <= bit_d;
      eop_q      <= eop_d;
      idle_q     <= idle_d;
      inb_q      <= inb_d;
      recving_q  <= recving_d;
      pause_q    <= pause_d;
      err_q      <= err_d;
    end
  end

  assign inb      = inb_q;
  assign recving  = recving_q;
  assign pause    = pause_q;
  assign rx_error = err_q;

endmodule
